// File: rtl/acc_pkg.sv
// Shared types for the FPU writeback path: tag/register/data widths, the FPU
// response record and the outstanding-entry record.
package acc_pkg;

  localparam int unsigned ACC_WB_ENTRIES = 4;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned TAG_W          = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [TAG_W-1:0]      tag_t;

  // Same field order as the FPU status word: invalid, div-zero, overflow, underflow, inexact.
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef struct packed {
    data_t   result;
    status_t status;
    tag_t    tag;
  } fpu_resp_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } wb_entry_t;

endpackage

// File: rtl/acc_lzc_free.sv
// Lowest-index-invalid finder: reports whether any entry is free and which
// free entry has the smallest index.
module acc_lzc_free #(
  parameter  int unsigned NUM_ENTRIES = 4,
  localparam int unsigned IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic [NUM_ENTRIES-1:0] valid_i,
  output logic                   found_o,
  output logic [IDX_W-1:0]       idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!valid_i[i] && !found_o) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/acc_fpu_writeback.sv
// Tracks outstanding FPU requests by tag and writes results back to the
// register file. Define ACC_WB_FFLAGS_EN to accumulate FPU status flags.
module acc_fpu_writeback
  import acc_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = ACC_WB_ENTRIES
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      alloc_valid_i,
  input  reg_addr_t alloc_rd_i,
  output logic      alloc_ready_o,
  output tag_t      alloc_tag_o,
  input  logic      resp_valid_i,
  input  fpu_resp_t resp_i,
  output logic      resp_ready_o,
  output logic      wb_valid_o,
  output reg_addr_t wb_rd_o,
  output data_t     wb_data_o,
  input  logic      wb_ready_i,
  output status_t   fflags_o,
  input  logic      fflags_clr_i,
  output logic      tag_err_o,
  output logic      busy_o
);

  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  wb_entry_t              entries_q [NUM_ENTRIES];
  wb_entry_t              entries_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_vec;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       resp_idx;
  logic                   tag_known;
  logic                   alloc_fire;
  logic                   resp_fire;

  logic      wb_valid_q, wb_valid_d;
  reg_addr_t wb_rd_q,    wb_rd_d;
  data_t     wb_data_q,  wb_data_d;
  logic      tag_err_q,  tag_err_d;

  always_comb begin
    valid_vec = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
    end
  end

  acc_lzc_free #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_free (
    .valid_i (valid_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  // Handshakes are suppressed while reset is held.
  assign alloc_ready_o = free_found && !rst_i;
  assign alloc_tag_o   = tag_t'(free_idx);
  assign resp_ready_o  = (!wb_valid_q || wb_ready_i) && !rst_i;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign resp_fire     = resp_valid_i && resp_ready_o;

  assign resp_idx  = resp_i.tag[IDX_W-1:0];
  assign tag_known = ({{(32-TAG_W){1'b0}}, resp_i.tag} < NUM_ENTRIES)
                     && entries_q[resp_idx].valid;

  always_comb begin
    entries_d  = entries_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    tag_err_d  = tag_err_q;

    if (wb_valid_q && wb_ready_i) begin
      wb_valid_d = 1'b0;
    end

    if (resp_fire) begin
      if (tag_known) begin
        wb_valid_d                = 1'b1;
        wb_rd_d                   = entries_q[resp_idx].rd;
        wb_data_d                 = resp_i.result;
        entries_d[resp_idx].valid = 1'b0;
      end else begin
        tag_err_d = 1'b1;
      end
    end

    // The allocated entry is always invalid, so it never collides with the freed one.
    if (alloc_fire) begin
      entries_d[free_idx].valid = 1'b1;
      entries_d[free_idx].rd    = alloc_rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      tag_err_q  <= tag_err_d;
    end
  end

`ifdef ACC_WB_FFLAGS_EN
  status_t fflags_q, fflags_d;

  always_comb begin
    fflags_d = fflags_clr_i ? '0 : fflags_q;
    if (resp_fire) begin
      fflags_d = fflags_d | resp_i.status;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
`else
  logic unused_fflags;
  assign unused_fflags = ^{fflags_clr_i, resp_i.status};
  assign fflags_o      = '0;
`endif

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign tag_err_o  = tag_err_q;
  assign busy_o     = (|valid_vec) || wb_valid_q;

endmodule

// File: tb/tb_acc_fpu_writeback.sv
// Bench for acc_fpu_writeback: directed vector table, reset-with-pending
// sequence, then randomized traffic against a behavioural model.
module tb_acc_fpu_writeback;
  import acc_pkg::*;

  localparam int unsigned N = 4;

  logic      clk = 1'b0;
  logic      rst_i;
  logic      alloc_valid_i;
  reg_addr_t alloc_rd_i;
  logic      alloc_ready_o;
  tag_t      alloc_tag_o;
  logic      resp_valid_i;
  fpu_resp_t resp_i;
  logic      resp_ready_o;
  logic      wb_valid_o;
  reg_addr_t wb_rd_o;
  data_t     wb_data_o;
  logic      wb_ready_i;
  status_t   fflags_o;
  logic      fflags_clr_i;
  logic      tag_err_o;
  logic      busy_o;

  always #5 clk = ~clk;

  acc_fpu_writeback #(
    .NUM_ENTRIES (N)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_rd_i    (alloc_rd_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_tag_o   (alloc_tag_o),
    .resp_valid_i  (resp_valid_i),
    .resp_i        (resp_i),
    .resp_ready_o  (resp_ready_o),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .wb_ready_i    (wb_ready_i),
    .fflags_o      (fflags_o),
    .fflags_clr_i  (fflags_clr_i),
    .tag_err_o     (tag_err_o),
    .busy_o        (busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] ff_exp(input logic [4:0] v);
`ifdef ACC_WB_FFLAGS_EN
    return v;
`else
    return 5'h00 & v;
`endif
  endfunction

  task automatic drive(input logic av, input logic [4:0] ard, input logic rv,
                       input logic [3:0] rtag, input logic [31:0] rres,
                       input logic [4:0] rstat, input logic wrdy, input logic clr);
    alloc_valid_i    = av;
    alloc_rd_i       = ard;
    resp_valid_i     = rv;
    resp_i.tag       = rtag;
    resp_i.result    = rres;
    resp_i.status    = rstat;
    wb_ready_i       = wrdy;
    fflags_clr_i     = clr;
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic        rv;
    logic [3:0]  rtag;
    logic [31:0] rres;
    logic [4:0]  rstat;
    logic        wrdy;
    logic        clr;
    logic        e_ar;
    logic [3:0]  e_at;
    logic        e_rr;
    logic        e_wv;
    logic [4:0]  e_wrd;
    logic [31:0] e_wd;
    logic        e_terr;
    logic        e_busy;
    logic [4:0]  e_ff;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic rv, input logic [3:0] rtag,
    input logic [31:0] rres, input logic [4:0] rstat, input logic wrdy, input logic clr,
    input logic e_ar, input logic [3:0] e_at, input logic e_rr, input logic e_wv,
    input logic [4:0] e_wrd, input logic [31:0] e_wd, input logic e_terr,
    input logic e_busy, input logic [4:0] e_ff);
    vec_t v;
    v.av = av; v.ard = ard; v.rv = rv; v.rtag = rtag; v.rres = rres; v.rstat = rstat;
    v.wrdy = wrdy; v.clr = clr; v.e_ar = e_ar; v.e_at = e_at; v.e_rr = e_rr;
    v.e_wv = e_wv; v.e_wrd = e_wrd; v.e_wd = e_wd; v.e_terr = e_terr;
    v.e_busy = e_busy; v.e_ff = e_ff;
    return v;
  endfunction

  // Behavioural model state
  bit          m_valid [N];
  logic [4:0]  m_rd    [N];
  bit          m_wv;
  logic [4:0]  m_wrd;
  logic [31:0] m_wd;
  bit          m_terr;
  logic [4:0]  m_ff;

  vec_t vecs[$];

  initial begin
    vec_t v;
    drive(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    rst_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.alloc_ready", 32'(alloc_ready_o), 32'd0);
    chk("rst.resp_ready",  32'(resp_ready_o),  32'd0);
    chk("rst.wb_valid",    32'(wb_valid_o),    32'd0);
    chk("rst.wb_rd",       32'(wb_rd_o),       32'd0);
    chk("rst.wb_data",     32'(wb_data_o),     32'd0);
    chk("rst.busy",        32'(busy_o),        32'd0);
    chk("rst.tag_err",     32'(tag_err_o),     32'd0);
    chk("rst.fflags",      32'(fflags_o),      32'd0);
    rst_i = 1'b0;

    //            av  ard    rv  tag   result         stat  wrdy clr | ar  at    rr  wv  wrd    wd             terr busy ff
    vecs.push_back(mk(1, 5'd5, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd0, 1, 0, 5'd0, 32'h0,         0, 0, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd0, 32'h3F800000,  5'h00, 1, 0,  1, 4'd1, 1, 0, 5'd0, 32'h0,         0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd0, 1, 1, 5'd5, 32'h3F800000,  0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd0, 1, 0, 5'd0, 32'h0,         0, 0, 5'h00));
    vecs.push_back(mk(1, 5'd1, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd0, 1, 0, 5'd0, 32'h0,         0, 0, 5'h00));
    vecs.push_back(mk(1, 5'd2, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd1, 1, 0, 5'd0, 32'h0,         0, 1, 5'h00));
    vecs.push_back(mk(1, 5'd3, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd2, 1, 0, 5'd0, 32'h0,         0, 1, 5'h00));
    vecs.push_back(mk(1, 5'd4, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd3, 1, 0, 5'd0, 32'h0,         0, 1, 5'h00));
    vecs.push_back(mk(1, 5'd9, 0, 4'd0, 32'h0,         5'h00, 1, 0,  0, 4'd0, 1, 0, 5'd0, 32'h0,         0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd2, 32'h22,        5'h00, 1, 0,  0, 4'd0, 1, 0, 5'd0, 32'h0,         0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 0, 4'd0, 32'h0,         5'h00, 0, 0,  1, 4'd2, 0, 1, 5'd3, 32'h22,        0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd0, 32'h11,        5'h00, 0, 0,  1, 4'd2, 0, 1, 5'd3, 32'h22,        0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd0, 32'h11,        5'h00, 0, 0,  1, 4'd2, 0, 1, 5'd3, 32'h22,        0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd0, 32'h11,        5'h00, 1, 0,  1, 4'd2, 1, 1, 5'd3, 32'h22,        0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd0, 1, 1, 5'd1, 32'h11,        0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd0, 1, 0, 5'd0, 32'h0,         0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd7, 32'h77,        5'h00, 1, 0,  1, 4'd0, 1, 0, 5'd0, 32'h0,         0, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd0, 1, 0, 5'd0, 32'h0,         1, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd1, 32'h1,         5'h00, 1, 0,  1, 4'd0, 1, 0, 5'd0, 32'h0,         1, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd3, 32'h3,         5'h10, 1, 0,  1, 4'd0, 1, 1, 5'd2, 32'h1,         1, 1, 5'h00));
    vecs.push_back(mk(0, 5'd0, 1, 4'd7, 32'h77,        5'h04, 1, 0,  1, 4'd0, 1, 1, 5'd4, 32'h3,         1, 1, 5'h10));
    vecs.push_back(mk(0, 5'd0, 0, 4'd0, 32'h0,         5'h00, 1, 1,  1, 4'd0, 1, 0, 5'd0, 32'h0,         1, 0, 5'h14));
    vecs.push_back(mk(0, 5'd0, 0, 4'd0, 32'h0,         5'h00, 1, 0,  1, 4'd0, 1, 0, 5'd0, 32'h0,         1, 0, 5'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.av, v.ard, v.rv, v.rtag, v.rres, v.rstat, v.wrdy, v.clr);
      #1;
      chk($sformatf("v%0d.alloc_ready", i), 32'(alloc_ready_o), 32'(v.e_ar));
      if (v.e_ar) chk($sformatf("v%0d.alloc_tag", i), 32'(alloc_tag_o), 32'(v.e_at));
      chk($sformatf("v%0d.resp_ready", i), 32'(resp_ready_o), 32'(v.e_rr));
      chk($sformatf("v%0d.wb_valid", i),   32'(wb_valid_o),   32'(v.e_wv));
      if (v.e_wv) begin
        chk($sformatf("v%0d.wb_rd", i),   32'(wb_rd_o),   32'(v.e_wrd));
        chk($sformatf("v%0d.wb_data", i), wb_data_o,      v.e_wd);
      end
      chk($sformatf("v%0d.tag_err", i), 32'(tag_err_o), 32'(v.e_terr));
      chk($sformatf("v%0d.busy", i),    32'(busy_o),    32'(v.e_busy));
      chk($sformatf("v%0d.fflags", i),  32'(fflags_o),  32'(ff_exp(v.e_ff)));
    end

    // Reset with two entries outstanding and a held writeback
    @(negedge clk); drive(1'b1, 5'd7, 1'b0, 4'd0, 32'h0, 5'h00, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 5'd8, 1'b0, 4'd0, 32'h0, 5'h00, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 5'd9, 1'b1, 4'd0, 32'hDEAD, 5'h1F, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 5'd0, 1'b0, 4'd0, 32'h0, 5'h00, 1'b0, 1'b0);
    #1;
    chk("rstseq.wb_valid_pre", 32'(wb_valid_o), 32'd1);
    chk("rstseq.wb_rd_pre",    32'(wb_rd_o),    32'd7);
    chk("rstseq.alloc_tag_pre", 32'(alloc_tag_o), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("rstseq.alloc_ready_in_rst", 32'(alloc_ready_o), 32'd0);
    chk("rstseq.resp_ready_in_rst",  32'(resp_ready_o),  32'd0);
    @(negedge clk); #1;
    chk("rstseq.wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rstseq.wb_rd",    32'(wb_rd_o),    32'd0);
    chk("rstseq.wb_data",  wb_data_o,       32'd0);
    chk("rstseq.tag_err",  32'(tag_err_o),  32'd0);
    chk("rstseq.fflags",   32'(fflags_o),   32'd0);
    chk("rstseq.busy",     32'(busy_o),     32'd0);
    rst_i = 1'b0;
    #1;
    chk("rstseq.alloc_ready_post", 32'(alloc_ready_o), 32'd1);
    chk("rstseq.alloc_tag_post",   32'(alloc_tag_o),   32'd0);
    chk("rstseq.resp_ready_post",  32'(resp_ready_o),  32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0;
      m_rd[k]    = 5'd0;
    end
    m_wv = 1'b0; m_wrd = 5'd0; m_wd = 32'd0; m_terr = 1'b0; m_ff = 5'd0;

    for (int c = 0; c < 400; c++) begin
      logic        av, rv, wrdy, clr;
      logic [4:0]  ard, rstat;
      logic [3:0]  rtag;
      logic [31:0] rres;
      int          free_tag;
      bit          e_ar, e_rr, e_busy, afire, rfire, wb_done;

      av    = ($urandom_range(0, 1) == 1);
      ard   = 5'($urandom_range(0, 31));
      rv    = ($urandom_range(0, 99) < 60);
      rtag  = 4'($urandom_range(0, 5));
      rres  = $urandom;
      rstat = 5'($urandom_range(0, 31));
      wrdy  = ($urandom_range(0, 99) < 70);
      clr   = ($urandom_range(0, 99) < 10);

      free_tag = -1;
      for (int k = N - 1; k >= 0; k--) if (!m_valid[k]) free_tag = k;
      e_ar   = (free_tag >= 0);
      e_rr   = !m_wv || wrdy;
      e_busy = m_wv;
      for (int k = 0; k < N; k++) if (m_valid[k]) e_busy = 1'b1;

      @(negedge clk);
      drive(av, ard, rv, rtag, rres, rstat, wrdy, clr);
      #1;
      chk($sformatf("r%0d.alloc_ready", c), 32'(alloc_ready_o), 32'(e_ar));
      if (e_ar) chk($sformatf("r%0d.alloc_tag", c), 32'(alloc_tag_o), 32'(free_tag));
      chk($sformatf("r%0d.resp_ready", c), 32'(resp_ready_o), 32'(e_rr));
      chk($sformatf("r%0d.wb_valid", c),   32'(wb_valid_o),   32'(m_wv));
      if (m_wv) begin
        chk($sformatf("r%0d.wb_rd", c),   32'(wb_rd_o), 32'(m_wrd));
        chk($sformatf("r%0d.wb_data", c), wb_data_o,    m_wd);
      end
      chk($sformatf("r%0d.tag_err", c), 32'(tag_err_o), 32'(m_terr));
      chk($sformatf("r%0d.busy", c),    32'(busy_o),    32'(e_busy));
      chk($sformatf("r%0d.fflags", c),  32'(fflags_o),  32'(ff_exp(m_ff)));

      afire   = av && e_ar;
      rfire   = rv && e_rr;
      wb_done = m_wv && wrdy;
      if (wb_done) m_wv = 1'b0;
      if (clr) m_ff = 5'd0;
      if (rfire) begin
        m_ff = m_ff | rstat;
        if (rtag < N && m_valid[rtag]) begin
          m_wv   = 1'b1;
          m_wrd  = m_rd[rtag];
          m_wd   = rres;
          m_valid[rtag] = 1'b0;
        end else begin
          m_terr = 1'b1;
        end
      end
      if (afire) begin
        m_valid[free_tag] = 1'b1;
        m_rd[free_tag]    = ard;
      end
    end

    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 4'd0, 32'h0, 5'h00, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
